// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_pkg                                                      |
// | Shared defaults, state encoding and the hard-wired zero address  |
// | for the multiport register file.                                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int                 STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_INIT = 1'b0;
  localparam logic [STATE_W-1:0] ST_RUN  = 1'b1;

  localparam int ZERO_REG = 0;

endpackage
`default_nettype wire

// File: rtl/regfile_multiport_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_multiport_if                                             |
// | Write port, packed read ports and ready flag of the register     |
// | file. The master drives addresses and write data, the slave      |
// | (register file) returns read data and ready.                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);

  logic                     writeEnable;
  logic [ADDR_W-1:0]        writeAddress;
  logic [DATA_W-1:0]        writeData;
  logic [NUM_RD*ADDR_W-1:0] readAddress;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic                     ready;

  modport master (
    output writeEnable, writeAddress, writeData, readAddress,
    input  readData, ready
  );

  modport slave (
    input  writeEnable, writeAddress, writeData, readAddress,
    output readData, ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_clear_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_clear_ctrl                                               |
// | Post-reset clear sequencer: walks entries 1..DEPTH-1 writing     |
// | zero, one per cycle, then raises ready and stays in RUN.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  wire logic              CLK,
  input  wire logic              RST_N,
  output logic                   o_ready,
  output logic                   o_clr_we,
  output logic [ADDR_W-1:0]      o_clr_addr
);

  // Entry 0 is hard-wired, so clearing starts at 1 and ends at all-ones.
  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               ready_q, ready_d;

  // State register: synchronous active-low reset restarts the clear walk.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      ptr_q   <= PTR_FIRST;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Next state: advance the pointer; the edge clearing the last entry enters RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (state_q == ST_INIT) begin
      if (ptr_q == PTR_LAST) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
  end

  // Outputs: clear strobe only while INIT and not held in reset.
  always_comb begin
    o_clr_we   = (state_q == ST_INIT) && RST_N;
    o_clr_addr = ptr_q;
    o_ready    = ready_q && RST_N;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_multiport                                                |
// | Parametrised register file: NUM_RD combinational read ports,     |
// | one write port, hard-wired zero register, optional same-cycle    |
// | write-to-read bypass and a post-reset clear sequence.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input wire logic          CLK,
  input wire logic          RST_N,
  regfile_multiport_if.slave bus
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .o_ready    (ready),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr)
  );

  assign bus.ready = ready;

  // User write is accepted only in RUN and never to the zero register.
  assign user_we = bus.writeEnable && ready && (bus.writeAddress != ZERO_ADDR);

  // Single array write port: clear sequencer and user writes are mutually exclusive.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else if (user_we) begin
      mem_d[bus.writeAddress] = bus.writeData;
    end
  end

  // Storage array; contents need no reset because the clear walk zeroes it.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = bus.readAddress[k*ADDR_W +: ADDR_W];

    // Read port k: zero in INIT or for address 0, else bypass or stored value.
    always_comb begin
      rd_data = '0;
      if (ready && (rd_addr != ZERO_ADDR)) begin
        if ((BYPASS != 0) && user_we && (bus.writeAddress == rd_addr)) begin
          rd_data = bus.writeData;
        end else begin
          rd_data = mem_q[rd_addr];
        end
      end
    end

    assign bus.readData[k*DATA_W +: DATA_W] = rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_multiport                                             |
// | Directed scoreboard bench for three register-file variants:      |
// | A = defaults (bypass on), B = bypass off, C = 4 ports, 8 deep.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_regfile_multiport;

  logic CLK;
  logic rst_a, rst_b, rst_c;

  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_a ();
  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_b ();
  regfile_multiport_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) if_c ();

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_a (
    .CLK (CLK), .RST_N (rst_a), .bus (if_a)
  );
  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_b (
    .CLK (CLK), .RST_N (rst_b), .bus (if_b)
  );
  regfile_multiport #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .BYPASS(1)) dut_c (
    .CLK (CLK), .RST_N (rst_c), .bus (if_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.exp = 'x;
    end else begin
      e = sb_q.pop_front();
    end
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: observed=%08h expected=%08h", e.tag, obs, e.exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cnt;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.writeEnable = 1'b0; if_a.writeAddress = '0; if_a.writeData = '0; if_a.readAddress = '0;
    if_b.writeEnable = 1'b0; if_b.writeAddress = '0; if_b.writeData = '0; if_b.readAddress = '0;
    if_c.writeEnable = 1'b0; if_c.writeAddress = '0; if_c.writeData = '0; if_c.readAddress = '0;

    // Reset held for two cycles.
    tick();
    tick();
    expect_val("a_ready_in_reset", 32'd0);   check({31'd0, if_a.ready});
    expect_val("a_rd0_in_reset", 32'd0);     check(if_a.readData[31:0]);
    expect_val("c_ready_in_reset", 32'd0);   check({31'd0, if_c.ready});

    // Release; hammer a write to addr 5 throughout INIT (must be dropped).
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.writeEnable  = 1'b1;
    if_a.writeAddress = 5'd5;
    if_a.writeData    = 32'hDEADBEEF;
    if_a.readAddress  = {5'd5, 5'd5};
    for (int i = 1; i <= 31; i++) begin
      tick();
      expect_val("a_ready_init_edge", (i == 31) ? 32'd1 : 32'd0);
      check({31'd0, if_a.ready});
      if (i == 1 || i == 5 || i == 30 || i == 31) begin
        expect_val("a_init_rd_p0", 32'd0); check(if_a.readData[31:0]);
        expect_val("a_init_rd_p1", 32'd0); check(if_a.readData[63:32]);
      end
      if (i == 6 || i == 7) begin
        expect_val("c_ready_edge", (i == 7) ? 32'd1 : 32'd0);
        check({31'd0, if_c.ready});
      end
      if (i == 30) if_a.writeEnable = 1'b0;
    end
    expect_val("b_ready_after_31", 32'd1); check({31'd0, if_b.ready});

    // Write 0x12345678 to addr 7: bypassed in the write cycle, stored after.
    if_a.readAddress = {5'd7, 5'd7};
    #1;
    expect_val("a_rd7_cleared", 32'd0); check(if_a.readData[31:0]);
    if_a.writeEnable  = 1'b1;
    if_a.writeAddress = 5'd7;
    if_a.writeData    = 32'h12345678;
    #1;
    expect_val("a_bypass_p0", 32'h12345678); check(if_a.readData[31:0]);
    expect_val("a_bypass_p1", 32'h12345678); check(if_a.readData[63:32]);
    tick();
    if_a.writeEnable = 1'b0;
    #1;
    expect_val("a_stored_p0", 32'h12345678); check(if_a.readData[31:0]);
    expect_val("a_stored_p1", 32'h12345678); check(if_a.readData[63:32]);

    // Write to addr 0 is dropped and addr 0 reads zero even with bypass.
    if_a.readAddress  = {5'd0, 5'd0};
    if_a.writeEnable  = 1'b1;
    if_a.writeAddress = 5'd0;
    if_a.writeData    = 32'hFFFFFFFF;
    #1;
    expect_val("a_zero_wcycle_p0", 32'd0); check(if_a.readData[31:0]);
    expect_val("a_zero_wcycle_p1", 32'd0); check(if_a.readData[63:32]);
    tick();
    if_a.writeEnable = 1'b0;
    #1;
    expect_val("a_zero_after_p0", 32'd0); check(if_a.readData[31:0]);
    expect_val("a_zero_after_p1", 32'd0); check(if_a.readData[63:32]);

    // No-bypass variant: old value visible until the edge.
    if_b.readAddress  = {5'd9, 5'd9};
    if_b.writeEnable  = 1'b1;
    if_b.writeAddress = 5'd9;
    if_b.writeData    = 32'hA;
    #1;
    expect_val("b_nobypass_first", 32'd0); check(if_b.readData[31:0]);
    tick();
    if_b.writeData = 32'hB;
    #1;
    expect_val("b_old_in_wcycle_p0", 32'hA); check(if_b.readData[31:0]);
    expect_val("b_old_in_wcycle_p1", 32'hA); check(if_b.readData[63:32]);
    tick();
    if_b.writeEnable = 1'b0;
    #1;
    expect_val("b_new_after_edge", 32'hB); check(if_b.readData[31:0]);

    // Reset during INIT at edge 10 restarts the clear walk.
    rst_a = 1'b0;
    #1;
    expect_val("a_ready_low_in_reset", 32'd0); check({31'd0, if_a.ready});
    tick();
    rst_a = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    expect_val("a_ready_before_midreset", 32'd0); check({31'd0, if_a.ready});
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 30 || i == 31) begin
        expect_val("a_ready_restart", (i == 31) ? 32'd1 : 32'd0);
        check({31'd0, if_a.ready});
      end
    end
    if_a.readAddress = {5'd7, 5'd7};
    #1;
    expect_val("a_rd7_recleared", 32'd0); check(if_a.readData[31:0]);

    // Fill A with value = address, then reset and confirm every entry clears.
    for (int a = 1; a <= 31; a++) begin
      if_a.writeEnable  = 1'b1;
      if_a.writeAddress = 5'(a);
      if_a.writeData    = 32'(a);
      tick();
    end
    if_a.writeEnable = 1'b0;
    if_a.readAddress = {5'd31, 5'd1};
    #1;
    expect_val("a_fill_p0_1", 32'd1);   check(if_a.readData[31:0]);
    expect_val("a_fill_p1_31", 32'd31); check(if_a.readData[63:32]);
    if_a.readAddress = {5'd18, 5'd17};
    #1;
    expect_val("a_fill_p0_17", 32'd17); check(if_a.readData[31:0]);
    expect_val("a_fill_p1_18", 32'd18); check(if_a.readData[63:32]);

    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    cnt = 0;
    while (!if_a.ready && cnt < 40) begin
      tick();
      cnt++;
    end
    expect_val("a_ready_after_refill_reset", 32'd1); check({31'd0, if_a.ready});
    expect_val("a_clear_edges", 32'd31);              check(32'(cnt));
    for (int a = 1; a <= 31; a++) begin
      if_a.readAddress = {5'(32 - a), 5'(a)};
      tick();
      expect_val("a_cleared_p0", 32'd0); check(if_a.readData[31:0]);
      expect_val("a_cleared_p1", 32'd0); check(if_a.readData[63:32]);
    end

    // C: 4 independent ports over an 8-entry file.
    for (int a = 1; a <= 7; a++) begin
      if_c.writeEnable  = 1'b1;
      if_c.writeAddress = 3'(a);
      if_c.writeData    = 32'(a * 32'h11);
      tick();
    end
    if_c.writeEnable = 1'b0;
    if_c.readAddress = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    for (int k = 0; k < 4; k++) begin
      expect_val("c_port_read_lo", 32'((k + 1) * 32'h11));
      check(if_c.readData[k*32 +: 32]);
    end
    if_c.readAddress = {3'd0, 3'd7, 3'd6, 3'd5};
    #1;
    for (int k = 0; k < 4; k++) begin
      expect_val("c_port_read_hi", (k == 3) ? 32'd0 : 32'((k + 5) * 32'h11));
      check(if_c.readData[k*32 +: 32]);
    end
    if_c.readAddress  = {3'd0, 3'd2, 3'd3, 3'd3};
    if_c.writeEnable  = 1'b1;
    if_c.writeAddress = 3'd3;
    if_c.writeData    = 32'hCAFEF00D;
    #1;
    expect_val("c_bypass_p0", 32'hCAFEF00D); check(if_c.readData[31:0]);
    expect_val("c_bypass_p1", 32'hCAFEF00D); check(if_c.readData[63:32]);
    expect_val("c_nomatch_p2", 32'h22);      check(if_c.readData[95:64]);
    expect_val("c_zero_p3", 32'd0);          check(if_c.readData[127:96]);
    tick();
    if_c.writeEnable = 1'b0;

    rst_c = 1'b0;
    tick();
    rst_c = 1'b1;
    cnt = 0;
    while (!if_c.ready && cnt < 20) begin
      tick();
      cnt++;
    end
    expect_val("c_clear_edges", 32'd7); check(32'(cnt));
    if_c.readAddress = {3'd7, 3'd6, 3'd5, 3'd4};
    #1;
    for (int k = 0; k < 4; k++) begin
      expect_val("c_cleared_hi", 32'd0); check(if_c.readData[k*32 +: 32]);
    end
    if_c.readAddress = {3'd1, 3'd2, 3'd3, 3'd1};
    #1;
    for (int k = 0; k < 4; k++) begin
      expect_val("c_cleared_lo", 32'd0); check(if_c.readData[k*32 +: 32]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
